// File: rtl/serial_adder_fsm_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..w-1; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < w) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_fsm_full_adder.sv
// Single-bit combinational full-adder cell.
module full_adder_behav (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry of one bit position.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell, one operand bit pair per clock.
module serial_adder_fsm
  import serial_adder_fsm_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;

  full_adder_behav u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Partial sum including the bit currently at the cell; only the upper
  // WIDTH-1 bits need storing since the lowest falls off on each shift.
  assign psum_nxt = {fa_sum, psum};
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, handshake outputs and operand-accept decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting, carry and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      psum  <= psum_nxt[WIDTH-1:1];
      carry <= fa_cout;
      if (!last_bit) cnt <= cnt + 1'b1;
    end
  end

  // Result registers update only on the final bit, holding otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last_bit) begin
      sum  <= psum_nxt;
      cout <= fa_cout;
    end
  end

endmodule
